// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, message-locking arbiter feeding NUM_REQ byte streams into one TX FIFO write port
module uart_tx_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 3,
  parameter int MAX_BURST  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ena,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);
  typedef enum logic {IDLE, LOCK} state_t;
  state_t state;
  logic [IW-1:0] owner, rr_ptr, win, cand;
  logic [CW-1:0] burst_cnt;
  logic found, xfer, release_now;
  assign busy        = state == LOCK;
  assign out_valid   = ena & busy & req_valid[owner];
  assign out_data    = busy ? req_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign req_ready   = (ena & busy & out_ready) ? grant : '0;
  assign xfer        = out_valid & out_ready;
  assign release_now = req_last[owner] | (burst_cnt == CW'(MAX_BURST - 1));
  always_comb begin
    win   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IW'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= '0;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else if (ena) begin
      if (state == IDLE) begin
        if (found) begin
          state     <= LOCK;
          owner     <= win;
          grant     <= NUM_REQ'(1) << win;
          burst_cnt <= '0;
        end
      end else if (xfer) begin
        if (release_now) begin
          state     <= IDLE;
          grant     <= '0;
          rr_ptr    <= (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
          burst_cnt <= '0;
        end else begin
          burst_cnt <= burst_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized checks of uart_tx_arbiter against a transaction-level model
module tb_uart_tx_arbiter;
  localparam int N = 3, W = 8, MB = 16;
  logic clk = 0, reset = 1, ena = 1, out_ready = 1;
  logic [N-1:0] req_valid = '0, req_last = '0, req_ready, grant;
  logic [N*W-1:0] req_data = '0;
  logic [W-1:0] out_data;
  logic out_valid, busy;
  typedef struct {logic [W-1:0] d; bit last;} item_t;
  item_t q[N][$];
  int gap_pct = 0;
  int m_own = -1, m_ptr = 0, m_cnt = 0;
  int log_q[$];
  int errors = 0, checks = 0;

  uart_tx_arbiter #(.DATA_WIDTH(W), .NUM_REQ(N), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset), .ena(ena), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic push(int i, int d, bit last);
    item_t it;
    it.d = W'(d);
    it.last = last;
    q[i].push_back(it);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bit gap = $urandom_range(99) < gap_pct;
      req_data[i*W +: W] = W'($urandom);
      req_last[i] = 1'($urandom);
      req_valid[i] = 1'b0;
      if (q[i].size() > 0) begin
        req_last[i] = q[i][0].last;
        if (!gap) begin
          req_valid[i] = 1'b1;
          req_data[i*W +: W] = q[i][0].d;
        end
      end
    end
  endtask

  // Model: owner -1 means idle; an idle cycle picks the first valid source from the
  // round-robin pointer; an owner keeps the grant until its last byte or MB bytes.
  task automatic advance();
    logic [N-1:0] rr, rv;
    logic [W-1:0] od;
    int wi;
    rr = req_ready;
    rv = req_valid;
    od = out_data;
    if (ena) begin
      if (m_own < 0) begin
        for (int k = 0; k < N; k++) begin
          wi = (m_ptr + k) % N;
          if (req_valid[wi]) begin
            m_own = wi;
            m_cnt = 0;
            break;
          end
        end
      end else if (req_valid[m_own] && out_ready) begin
        m_cnt++;
        if (req_last[m_own] || m_cnt == MB) begin
          m_ptr = (m_own + 1) % N;
          m_own = -1;
        end
      end
    end
    @(posedge clk);
    for (int i = 0; i < N; i++)
      if (rr[i] && rv[i]) begin
        log_q.push_back(i * 256 + int'(od));
        void'(q[i].pop_front());
      end
    @(negedge clk);
    drive();
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    ena = 1;
    out_ready = 1;
    gap_pct = 0;
    for (int i = 0; i < N; i++) q[i].delete();
    log_q.delete();
    m_own = -1;
    m_ptr = 0;
    m_cnt = 0;
    @(negedge clk);
    reset = 0;
    drive();
    #1;
  endtask

  task automatic drain();
    int n = 0;
    ena = 1;
    out_ready = 1;
    gap_pct = 0;
    drive();
    #1;
    while ((q[0].size() + q[1].size() + q[2].size() > 0 || busy) && n < 300) begin
      advance();
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL drain_timeout: still pending after %0d cycles, required drained", n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (grant !== 3'b000) begin errors++; $display("FAIL reset_grant: got %b want 000", grant); end
    checks++;
    if ({out_valid, busy, req_ready} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got valid=%b busy=%b ready=%b want all 0", out_valid, busy, req_ready);
    end
    checks++;
    if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", out_data); end
    push(1, 8'h11, 1);
    drive();
    #1;
    advance();
    advance();
    push(2, 8'h21, 0);
    push(2, 8'h22, 0);
    push(2, 8'h23, 1);
    drive();
    #1;
    advance();
    advance();
    checks++;
    if (busy !== 1'b1 || grant !== 3'b100) begin
      errors++; $display("FAIL reset_prelock: got busy=%b grant=%b want 1/100", busy, grant);
    end
    #1 reset = 1;
    #1;
    checks++;
    if (grant !== 3'b000 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_midlock: got grant=%b valid=%b busy=%b want 000/0/0", grant, out_valid, busy);
    end
    for (int i = 0; i < N; i++) q[i].delete();
    m_own = -1;
    m_ptr = 0;
    m_cnt = 0;
    push(1, 8'h31, 1);
    push(2, 8'h32, 1);
    @(negedge clk);
    reset = 0;
    drive();
    #1;
    advance();
    checks++;
    if (grant !== 3'b010) begin errors++; $display("FAIL reset_rrptr: got grant=%b want 010", grant); end
    drain();
  endtask

  task automatic test_single();
    logic [2:0] eg[5];
    logic ev[5];
    logic [7:0] ed[5];
    eg = '{3'b000, 3'b010, 3'b010, 3'b010, 3'b000};
    ev = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    ed = '{8'h00, 8'h41, 8'h42, 8'h43, 8'h00};
    do_reset();
    push(1, 8'h41, 0);
    push(1, 8'h42, 0);
    push(1, 8'h43, 1);
    drive();
    #1;
    for (int t = 0; t < 5; t++) begin
      checks++;
      if (grant !== eg[t] || out_valid !== ev[t] || out_data !== ed[t]) begin
        errors++;
        $display("FAIL single_cycle%0d: got grant=%b valid=%b data=%h want %b/%b/%h",
                 t, grant, out_valid, out_data, eg[t], ev[t], ed[t]);
      end
      advance();
    end
  endtask

  task automatic test_round_robin();
    int exp[$];
    do_reset();
    for (int i = 0; i < N; i++)
      for (int r = 0; r < 2; r++) push(i, 16 * i + r, 1);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) exp.push_back(i * 256 + 16 * i + r);
    drain();
    checks++;
    if (log_q.size() != exp.size()) begin
      errors++; $display("FAIL rr_count: got %0d bytes want %0d", log_q.size(), exp.size());
    end
    for (int k = 0; k < exp.size() && k < log_q.size(); k++) begin
      checks++;
      if (log_q[k] !== exp[k]) begin
        errors++; $display("FAIL rr_order[%0d]: got src%0d/%h want src%0d/%h", k,
                           log_q[k] / 256, log_q[k] % 256, exp[k] / 256, exp[k] % 256);
      end
    end
  endtask

  task automatic test_burst_cap();
    int exp[$];
    do_reset();
    for (int j = 0; j < 20; j++) push(0, j, j == 19);
    push(2, 8'hEE, 1);
    for (int j = 0; j < 16; j++) exp.push_back(j);
    exp.push_back(2 * 256 + 8'hEE);
    for (int j = 16; j < 20; j++) exp.push_back(j);
    drain();
    checks++;
    if (log_q.size() != exp.size()) begin
      errors++; $display("FAIL burst_count: got %0d bytes want %0d", log_q.size(), exp.size());
    end
    for (int k = 0; k < exp.size() && k < log_q.size(); k++) begin
      checks++;
      if (log_q[k] !== exp[k]) begin
        errors++; $display("FAIL burst_order[%0d]: got src%0d/%h want src%0d/%h", k,
                           log_q[k] / 256, log_q[k] % 256, exp[k] / 256, exp[k] % 256);
      end
    end
  endtask

  task automatic test_backpressure();
    bit pat[4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int j = 0; j < 4; j++) push(0, 8'h50 + j, j == 3);
    drive();
    #1;
    for (int t = 0; t < 16; t++) begin
      out_ready = pat[t % 4];
      #1;
      if (busy) begin
        checks++;
        if (req_ready !== {2'b00, out_ready}) begin
          errors++; $display("FAIL bp_ready: got %b want %b", req_ready, {2'b00, out_ready});
        end
        if (q[0].size() > 0) begin
          checks++;
          if (out_valid !== 1'b1 || out_data !== q[0][0].d) begin
            errors++; $display("FAIL bp_data: got valid=%b data=%h want 1/%h", out_valid, out_data, q[0][0].d);
          end
        end
      end
      advance();
    end
    drain();
    checks++;
    if (log_q.size() != 4) begin errors++; $display("FAIL bp_count: got %0d bytes want 4", log_q.size()); end
    for (int k = 0; k < 4 && k < log_q.size(); k++) begin
      checks++;
      if (log_q[k] !== 8'h50 + k) begin
        errors++; $display("FAIL bp_byte[%0d]: got %h want %h", k, log_q[k], 8'h50 + k);
      end
    end
  endtask

  task automatic test_ena();
    do_reset();
    for (int j = 0; j < 6; j++) push(1, 8'h60 + j, j == 5);
    drive();
    #1;
    advance();
    advance();
    advance();
    ena = 0;
    for (int t = 0; t < 5; t++) begin
      #1;
      checks++;
      if (out_valid !== 1'b0 || req_ready !== 3'b000 || grant !== 3'b010 || busy !== 1'b1) begin
        errors++; $display("FAIL ena_hold%0d: got valid=%b ready=%b grant=%b busy=%b want 0/000/010/1",
                           t, out_valid, req_ready, grant, busy);
      end
      advance();
    end
    checks++;
    if (log_q.size() != 2) begin errors++; $display("FAIL ena_frozen: got %0d bytes want 2", log_q.size()); end
    drain();
    checks++;
    if (log_q.size() != 6) begin errors++; $display("FAIL ena_count: got %0d bytes want 6", log_q.size()); end
    for (int k = 0; k < 6 && k < log_q.size(); k++) begin
      checks++;
      if (log_q[k] !== 256 + 8'h60 + k) begin
        errors++; $display("FAIL ena_byte[%0d]: got %h want %h", k, log_q[k], 256 + 8'h60 + k);
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] eg, er;
    logic ev;
    logic [W-1:0] ed;
    int r, len;
    do_reset();
    gap_pct = 15;
    for (int c = 0; c < 600; c++) begin
      r = $urandom_range(N - 1);
      if (q[r].size() < 3) begin
        len = $urandom_range(1, 22);
        for (int j = 0; j < len; j++) push(r, $urandom_range(255), j == len - 1);
      end
      ena = $urandom_range(99) >= 10;
      out_ready = $urandom_range(99) < 70;
      drive();
      #1;
      eg = (m_own < 0) ? '0 : N'(1) << m_own;
      ev = 1'b0;
      ed = '0;
      if (m_own >= 0) begin
        ev = ena && req_valid[m_own];
        ed = req_data[m_own*W +: W];
      end
      er = (ena && m_own >= 0 && out_ready) ? eg : '0;
      checks++;
      if (grant !== eg || busy !== (m_own >= 0)) begin
        errors++; $display("FAIL rand_grant c%0d: got grant=%b busy=%b want %b/%b", c, grant, busy, eg, m_own >= 0);
      end
      checks++;
      if (out_valid !== ev || (ev && out_data !== ed)) begin
        errors++; $display("FAIL rand_out c%0d: got valid=%b data=%h want %b/%h", c, out_valid, out_data, ev, ed);
      end
      checks++;
      if (req_ready !== er) begin
        errors++; $display("FAIL rand_ready c%0d: got %b want %b", c, req_ready, er);
      end
      advance();
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_burst_cap();
    test_backpressure();
    test_ena();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
